vga_background_scanner: RTL and testbench

- Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Drives the linear pixel address into the combinational background ROM (`addr` 19 bits, `data` 12-bit RGB444). Registers the returned pixel, muxes in an optional sprite/overlay pixel, and drives the VGA pins with sync aligned to the colour data.
- Also gives game logic the current pixel coordinates and a once-per-frame tick.

---
 rtl/vga_background_scanner.sv | 115 +++++++++++
 tb/tb_vga_background_scanner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_background_scanner.sv
// 640x480@60 VGA scanner: pixel timing, incremental background ROM addressing,
// overlay mux and sync/colour output registers aligned one pixel behind the counters.
module vga_background_scanner #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [18:0] rom_addr,
  input  logic [11:0] rom_data,
  input  logic        overlay_valid,
  input  logic [11:0] overlay_rgb,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_tick,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       X_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       X_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0]       Y_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0]       Y_VIS_M1  = 10'(V_VISIBLE - 1);
  localparam logic [9:0]       HS_START  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]       HS_END    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0]       VS_START  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]       VS_END    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [18:0]      ADDR_LAST = 19'(H_VISIBLE * V_VISIBLE - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [18:0]      addr_q, addr_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs_q, hs_d, vs_q, vs_d, frame_q, frame_d;
  logic             tick, visible;

  assign tick    = (div_q == DIV_LAST);
  assign visible = (x_q < X_VIS) && (y_q < Y_VIS);

  // rom_addr tracks the next visible pixel incrementally, so no y*640 multiply is needed
  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    rgb_d   = rgb_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    frame_d = 1'b0;
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
        addr_d = '0;
      end else if (visible) begin
        addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
      end
      rgb_d   = visible ? (overlay_valid ? overlay_rgb : rom_data) : 12'h000;
      hs_d    = !((x_q >= HS_START) && (x_q <= HS_END));
      vs_d    = !((y_q >= VS_START) && (y_q <= VS_END));
      frame_d = (x_q == X_LAST) && (y_q == Y_VIS_M1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      rgb_q   <= 12'h000;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      frame_q <= frame_d;
    end
  end

  assign rom_addr   = addr_q;
  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign pixel_tick = tick;
  assign frame_tick = frame_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign rgb        = rgb_q;

endmodule

// File: tb/tb_vga_background_scanner.sv
// Self-checking bench: full-size timing for line/overlay/reset behaviour, plus a shrunken-timing
// instance so whole frames (vsync, frame_tick, address wrap) fit in a short run.
module tb_vga_background_scanner;

  logic        clk = 1'b0;
  logic        rst_n1, rst_n2;
  logic [18:0] rom_addr1, rom_addr2;
  logic [11:0] rom_data1, rom_data2;
  logic        overlay_valid;
  logic [11:0] overlay_rgb;
  logic [9:0]  x1, y1, x2, y2;
  logic        tick1, tick2, ft1, ft2, hs1, hs2, vs1, vs2;
  logic [11:0] rgb1, rgb2;
  logic        rom_mode;
  int          cur;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input logic [18:0] a, input logic mode);
    return mode ? 12'h0A5 : (a[11:0] ^ {5'b0, a[18:12]} ^ 12'h3C6);
  endfunction

  assign rom_data1 = rom_fn(rom_addr1, rom_mode);
  assign rom_data2 = rom_fn(rom_addr2, rom_mode);

  vga_background_scanner dut1 (
    .clk(clk), .rst_n(rst_n1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .overlay_valid(overlay_valid), .overlay_rgb(overlay_rgb),
    .pixel_x(x1), .pixel_y(y1), .pixel_tick(tick1), .frame_tick(ft1),
    .hsync(hs1), .vsync(vs1), .rgb(rgb1)
  );

  vga_background_scanner #(
    .CLK_DIV(4), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .overlay_valid(overlay_valid), .overlay_rgb(overlay_rgb),
    .pixel_x(x2), .pixel_y(y2), .pixel_tick(tick2), .frame_tick(ft2),
    .hsync(hs2), .vsync(vs2), .rgb(rgb2)
  );

  // Reference timing per instance: {visible, front porch, sync, back porch}
  int HV[2]  = '{640, 8};
  int HFP[2] = '{16, 2};
  int HS[2]  = '{96, 3};
  int HBP[2] = '{48, 2};
  int VV[2]  = '{480, 4};
  int VFP[2] = '{10, 1};
  int VS[2]  = '{2, 2};
  int VBP[2] = '{33, 1};

  logic [18:0] o_addr;
  logic [9:0]  o_x, o_y;
  logic        o_tick, o_ft, o_hs, o_vs;
  logic [11:0] o_rgb;
  always_comb begin
    o_addr = (cur == 1) ? rom_addr2 : rom_addr1;
    o_x    = (cur == 1) ? x2 : x1;
    o_y    = (cur == 1) ? y2 : y1;
    o_tick = (cur == 1) ? tick2 : tick1;
    o_ft   = (cur == 1) ? ft2 : ft1;
    o_hs   = (cur == 1) ? hs2 : hs1;
    o_vs   = (cur == 1) ? vs2 : vs1;
    o_rgb  = (cur == 1) ? rgb2 : rgb1;
  end

  int          n;
  int          frame_pulses;
  logic [11:0] exp_rgb;
  logic        exp_hs, exp_vs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (inst %0d tick %0d)", tag, obs, exp, cur, n);
    end
  endtask

  function automatic int h_total(input int i);
    return HV[i] + HFP[i] + HS[i] + HBP[i];
  endfunction

  function automatic int v_total(input int i);
    return VV[i] + VFP[i] + VS[i] + VBP[i];
  endfunction

  // Address of the next visible pixel = count of visible pixels already scanned this frame
  function automatic logic [18:0] model_addr(input int i, input int x, input int y);
    int v;
    if (y >= VV[i]) return 19'd0;
    v = y * HV[i] + ((x < HV[i]) ? x : HV[i]);
    if (v == HV[i] * VV[i]) return 19'd0;
    return 19'(v);
  endfunction

  function automatic int pos_x(input int i, input int t);
    return (t % (h_total(i) * v_total(i))) % h_total(i);
  endfunction

  function automatic int pos_y(input int i, input int t);
    return (t % (h_total(i) * v_total(i))) / h_total(i);
  endfunction

  task automatic checkReset();
    check("reset_x", 32'(o_x), 32'd0);
    check("reset_y", 32'(o_y), 32'd0);
    check("reset_addr", 32'(o_addr), 32'd0);
    check("reset_tick", 32'(o_tick), 32'd0);
    check("reset_frame_tick", 32'(o_ft), 32'd0);
    check("reset_hsync", 32'(o_hs), 32'd1);
    check("reset_vsync", 32'(o_vs), 32'd1);
    check("reset_rgb", 32'(o_rgb), 32'd0);
  endtask

  task automatic checkOutput();
    int x, y;
    x = pos_x(cur, n);
    y = pos_y(cur, n);
    check("pixel_x", 32'(o_x), 32'(x));
    check("pixel_y", 32'(o_y), 32'(y));
    check("rom_addr", 32'(o_addr), 32'(model_addr(cur, x, y)));
    check("rgb", 32'(o_rgb), 32'(exp_rgb));
    check("hsync", 32'(o_hs), 32'(exp_hs));
    check("vsync", 32'(o_vs), 32'(exp_vs));
    check("frame_tick", 32'(o_ft), 32'((x == 0) && (y == VV[cur])));
    check("tick_after_edge", 32'(o_tick), 32'd0);
    if (o_ft) frame_pulses++;
  endtask

  // Predict the stage-1 result for the current position, then advance one pixel tick
  task automatic applyStimulus(input logic ov, input logic [11:0] orgb);
    int x, y, cnt, hs0, vs0;
    logic vis;
    logic [11:0] rom;
    overlay_valid = ov;
    overlay_rgb   = orgb;
    x   = pos_x(cur, n);
    y   = pos_y(cur, n);
    vis = (x < HV[cur]) && (y < VV[cur]);
    rom = rom_fn(model_addr(cur, x, y), rom_mode);
    exp_rgb = vis ? (ov ? orgb : rom) : 12'h000;
    hs0 = HV[cur] + HFP[cur];
    vs0 = VV[cur] + VFP[cur];
    exp_hs = !((x >= hs0) && (x < hs0 + HS[cur]));
    exp_vs = !((y >= vs0) && (y < vs0 + VS[cur]));
    cnt = 0;
    while (!o_tick && cnt < 16) begin
      @(posedge clk);
      #1;
      cnt++;
      check("frame_tick_idle", 32'(o_ft), 32'd0);
    end
    check("clocks_to_tick", 32'(cnt), 32'd3);
    @(posedge clk);
    #1;
    n++;
    checkOutput();
  endtask

  task automatic runRandom(input int count);
    for (int i = 0; i < count; i++)
      applyStimulus(($urandom_range(0, 3) == 0), 12'($urandom));
  endtask

  task automatic doReset(input int inst);
    if (inst == 0) rst_n1 = 1'b0; else rst_n2 = 1'b0;
    @(posedge clk);
    #1;
    checkReset();
    @(posedge clk);
    #1;
    checkReset();
    if (inst == 0) rst_n1 = 1'b1; else rst_n2 = 1'b1;
    n = 0;
  endtask

  initial begin
    rst_n1 = 1'b0;
    rst_n2 = 1'b0;
    rom_mode = 1'b0;
    overlay_valid = 1'b0;
    overlay_rgb = 12'h000;
    cur = 0;
    n = 0;
    frame_pulses = 0;
    @(posedge clk);
    #1;

    doReset(0);
    runRandom(800 + 98);
    rom_mode = 1'b1;
    applyStimulus(1'b0, 12'hF00);
    applyStimulus(1'b0, 12'hF00);
    applyStimulus(1'b1, 12'hF00);
    check("overlay_hit", 32'(rgb1), 32'h0F00);
    applyStimulus(1'b0, 12'hF00);
    check("overlay_neighbour", 32'(rgb1), 32'h00A5);
    applyStimulus(1'b0, 12'hF00);
    rom_mode = 1'b0;
    runRandom(700 - 103);
    applyStimulus(1'b1, 12'hF00);
    check("overlay_in_blank", 32'(rgb1), 32'h0000);
    runRandom(800 + 320 - 701);

    doReset(0);
    runRandom(900);

    cur = 1;
    doReset(1);
    frame_pulses = 0;
    runRandom(3 * 120 + 5);
    check("frame_pulse_count", 32'(frame_pulses), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
